reg_alu_datapath: RTL and testbench
===================================

Name: reg_alu_datapath

Overview:
Register-file-plus-ALU datapath stage driven by the sequencing FSM.
- Each clock it reads two registers selected by regACont/regBCont and applies the operation in AluOp.
- On the rising edge it writes the result into the register selected by the one-hot regControl, and updates the processor status flags.
- It exposes both read buses, the live ALU result and a registered copy of the last written result for board-level display.

Parameters:
WIDTH, 16, datapath and register width in bits
NREGS, 16, number of registers; fixed to match the 16-bit one-hot regControl and 4-bit selects

Ports:
clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous active-low reset
regControl  input  16  one-hot register write enable; bit i writes register i
regACont  input  4  read select for bus A
regBCont  input  4  read select for bus B
AluOp  input  8  ALU operation code
immediate  input  16  immediate operand for ADDI/MOVI/LUI
busA  output  16  current contents of register regACont
busB  output  16  current contents of register regBCont
aluResult  output  16  combinational ALU result
lastResult  output  16  registered value of the most recent committed write
flags  output  5  {C,L,F,Z,N} status register
errSticky  output  1  set when a multi-hot regControl is seen; cleared only by reset

Behaviour:
- Reset (Reset low, asynchronous): all NREGS registers, flags, lastResult and errSticky go to 0 immediately. Held through the first rising edge after release.
- Reads are combinational from stored state.
  - Read and write to the same register in one cycle: bus shows the old value; the new value is visible after the edge.
- AluOp encoding, A = busA, B = busB, I = immediate:
  - 0x00 MOV → B
  - 0x01 ADD → A+B
  - 0x02 ADDI → A+I
  - 0x03 SUB → A−B
  - 0x04 AND
  - 0x05 OR
  - 0x06 XOR
  - 0x07 NOT → ~A
  - 0x08 LSH → A << B[3:0]
  - 0x09 RSH → A >> B[3:0], logical
  - 0x0A ASH → A >>> B[3:0], arithmetic
  - 0x0B CMP → A−B, flags only
  - 0x0C LUI → {I[7:0], 8'h00}
  - 0x0D MOVI → I
  - Any other code: aluResult = 0, no register write, flags hold.
- All arithmetic is modulo 2^16.
  - Shift amounts of 0 return A unchanged.
  - Shifts of 15 are legal.
- Write commit on rising edge, only when all of the following hold:
  - regControl has exactly one bit set;
  - opcode is valid;
  - opcode ≠ CMP.
  - On commit: register[i] ← aluResult and lastResult ← aluResult.
- regControl = 0: no write, no error.
- regControl with ≥2 bits set: no write, errSticky ← 1, flags still update per opcode.
- Flags update on the edge only for ADD, ADDI, SUB and CMP; all other ops hold flags.
  - C: carry out (ADD/ADDI), or borrow (SUB/CMP).
  - F: signed overflow.
  - Z: result == 0.
  - N: signed A < B (SUB/CMP); sign of result (ADD/ADDI).
  - L: unsigned A < B (SUB/CMP); 0 for ADD/ADDI.
- Latency: operands to aluResult is 0 cycles; aluResult to register, lastResult and flags is 1 edge.
- Reset asserted mid-sequence discards any pending write in that cycle.

Test Plan:
1. Reset low then high; MOVI I=0x0001, regControl=0x0003 (multi-hot) → no write, errSticky=1, R0=R1=0. Then MOVI I=1 with regControl=0x0001, then 0x0002 → R0=R1=1, lastResult=1.
2. R1=1; LSH A=R1, B=R1 (regControl=0x0004) → R2=0x0002. Then LSH A=R2, B=R2 into R3 → R3=0x0008.
3. R3=8, R4=7; SUB A=R4, B=R3 into R6 → R6=0xFFFF, C=1, N=1, L=1, Z=0, F=0. Then CMP R3,R3 → Z=1, no register changes.
4. ADD 0x7FFF+0x0001 → 0x8000, F=1, N=1, C=0. ADD 0xFFFF+0x0001 → 0x0000, C=1, Z=1.
5. Same-cycle read/write of R5 (old 0x1234, MOVI 0xABCD) → busA=0x1234 before the edge, 0xABCD after. Invalid AluOp=0x20 → no write, flags unchanged.
6. Assert Reset mid-stream with regControl=0x0001 and AluOp=MOVI 0x5555 → R0 stays 0, all outputs 0 until Reset is released.

Source files
------------

// File: rtl/reg_alu_datapath.sv
// Purpose: 16-entry register file feeding a single-cycle ALU, with write-back, status flags and a sticky select error.
// Latency: operands to aluResult combinational; register, lastResult and flags update on the next rising edge.
// Backpressure: none; the sequencing FSM owns every cycle and the stage accepts whatever it is driven with.
//
// Ports:
//   clock       rising-edge clock for all state
//   Reset       asynchronous active-low reset
//   regControl  one-hot write enable, bit i writes register i
//   regACont    read select for busA
//   regBCont    read select for busB
//   AluOp       operation code
//   immediate   operand for ADDI / MOVI / LUI
//   busA, busB  current contents of the selected registers
//   aluResult   combinational ALU result
//   lastResult  value of the most recent committed write
//   flags       {C,L,F,Z,N} status register
//   errSticky   set on a multi-hot regControl, cleared only by Reset
module reg_alu_datapath #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [NREGS-1:0] regControl,
   input  logic [3:0]       regACont,
   input  logic [3:0]       regBCont,
   input  logic [7:0]       AluOp,
   input  logic [WIDTH-1:0] immediate,
   output logic [WIDTH-1:0] busA,
   output logic [WIDTH-1:0] busB,
   output logic [WIDTH-1:0] aluResult,
   output logic [WIDTH-1:0] lastResult,
   output logic [4:0]       flags,
   output logic             errSticky
);

   typedef enum logic [7:0] {
      OP_MOV  = 8'h00,
      OP_ADD  = 8'h01,
      OP_ADDI = 8'h02,
      OP_SUB  = 8'h03,
      OP_AND  = 8'h04,
      OP_OR   = 8'h05,
      OP_XOR  = 8'h06,
      OP_NOT  = 8'h07,
      OP_LSH  = 8'h08,
      OP_RSH  = 8'h09,
      OP_ASH  = 8'h0A,
      OP_CMP  = 8'h0B,
      OP_LUI  = 8'h0C,
      OP_MOVI = 8'h0D
   } alu_op_t;

   logic [WIDTH-1:0] regs [NREGS];

   // Low from reset until the first rising edge after release; that edge
   // only arms the stage, so nothing commits on it.
   logic             armed;

   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_dif;
   logic [3:0]       shamt;
   logic [WIDTH-1:0] alu_raw;
   logic             op_valid;
   logic             op_writes;
   logic             flag_upd;
   logic [4:0]       flags_nxt;
   logic             multi_hot;
   logic             one_hot;
   logic             commit;

   assign busA = regs[regACont];
   assign busB = regs[regBCont];

   assign add_b   = (AluOp == OP_ADDI) ? immediate : busB;
   assign add_sum = {1'b0, busA} + {1'b0, add_b};
   // The extra top bit of the difference is the borrow, i.e. unsigned A < B.
   assign sub_dif = {1'b0, busA} - {1'b0, busB};
   assign shamt   = busB[3:0];

   // x & (x-1) clears the lowest set bit, so anything left means >= 2 bits set.
   assign multi_hot = |(regControl & (regControl - 1'b1));
   assign one_hot   = (|regControl) && !multi_hot;

   always_comb begin
      alu_raw   = '0;
      op_valid  = 1'b1;
      op_writes = 1'b1;
      flag_upd  = 1'b0;
      flags_nxt = flags;
      case (AluOp)
         OP_MOV:  alu_raw = busB;
         OP_ADD, OP_ADDI: begin
            alu_raw   = add_sum[WIDTH-1:0];
            flag_upd  = 1'b1;
            flags_nxt = {add_sum[WIDTH],
                         1'b0,
                         (busA[WIDTH-1] == add_b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != busA[WIDTH-1]),
                         (add_sum[WIDTH-1:0] == '0),
                         add_sum[WIDTH-1]};
         end
         OP_SUB, OP_CMP: begin
            alu_raw   = sub_dif[WIDTH-1:0];
            op_writes = (AluOp != OP_CMP);
            flag_upd  = 1'b1;
            flags_nxt = {sub_dif[WIDTH],
                         sub_dif[WIDTH],
                         (busA[WIDTH-1] != busB[WIDTH-1]) &&
                            (sub_dif[WIDTH-1] != busA[WIDTH-1]),
                         (sub_dif[WIDTH-1:0] == '0),
                         ($signed(busA) < $signed(busB))};
         end
         OP_AND:  alu_raw = busA & busB;
         OP_OR:   alu_raw = busA | busB;
         OP_XOR:  alu_raw = busA ^ busB;
         OP_NOT:  alu_raw = ~busA;
         OP_LSH:  alu_raw = busA << shamt;
         OP_RSH:  alu_raw = busA >> shamt;
         OP_ASH:  alu_raw = $unsigned($signed(busA) >>> shamt);
         OP_LUI:  alu_raw = {immediate[7:0], 8'h00};
         OP_MOVI: alu_raw = immediate;
         default: begin
            op_valid  = 1'b0;
            op_writes = 1'b0;
         end
      endcase
   end

   assign commit    = armed && one_hot && op_valid && op_writes;
   // Forced to zero while the stage is unarmed so every output reads 0
   // during reset and its release cycle.
   assign aluResult = armed ? alu_raw : '0;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         armed      <= 1'b0;
         lastResult <= '0;
         flags      <= '0;
         errSticky  <= 1'b0;
      end else if (!armed) begin
         armed <= 1'b1;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (commit && regControl[i]) begin
               regs[i] <= alu_raw;
            end
         end
         if (commit) begin
            lastResult <= alu_raw;
         end
         if (flag_upd) begin
            flags <= flags_nxt;
         end
         if (multi_hot) begin
            errSticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_alu_datapath.sv
module tb_reg_alu_datapath;

   localparam logic [7:0] MOV  = 8'h00, ADD = 8'h01, ADDI = 8'h02, SUB = 8'h03,
                          AND_ = 8'h04, OR_ = 8'h05, XOR_ = 8'h06, NOT_ = 8'h07,
                          LSH  = 8'h08, RSH = 8'h09, ASH = 8'h0A, CMP = 8'h0B,
                          LUI  = 8'h0C, MOVI = 8'h0D;

   logic        clock;
   logic        Reset;
   logic [15:0] regControl;
   logic [3:0]  regACont;
   logic [3:0]  regBCont;
   logic [7:0]  AluOp;
   logic [15:0] immediate;
   logic [15:0] busA;
   logic [15:0] busB;
   logic [15:0] aluResult;
   logic [15:0] lastResult;
   logic [4:0]  flags;
   logic        errSticky;

   int errors = 0;
   int checks = 0;

   reg_alu_datapath dut (
      .clock      (clock),
      .Reset      (Reset),
      .regControl (regControl),
      .regACont   (regACont),
      .regBCont   (regBCont),
      .AluOp      (AluOp),
      .immediate  (immediate),
      .busA       (busA),
      .busB       (busB),
      .aluResult  (aluResult),
      .lastResult (lastResult),
      .flags      (flags),
      .errSticky  (errSticky)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // flags are {C,L,F,Z,N}
   typedef struct {
      logic [15:0] rc;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [7:0]  op;
      logic [15:0] imm;
      logic [15:0] ea;     // busA before the edge
      logic [15:0] ealu;   // aluResult before the edge
      logic [4:0]  ef;     // flags after the edge
      logic [15:0] elast;  // lastResult after the edge
      logic        eerr;   // errSticky after the edge
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(logic [15:0] rc, logic [3:0] ra, logic [3:0] rb,
                              logic [7:0] op, logic [15:0] imm, logic [15:0] ea,
                              logic [15:0] ealu, logic [4:0] ef, logic [15:0] elast,
                              logic eerr);
      vec_t r;
      r.rc = rc; r.ra = ra; r.rb = rb; r.op = op; r.imm = imm;
      r.ea = ea; r.ealu = ealu; r.ef = ef; r.elast = elast; r.eerr = eerr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] rc, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [7:0] op, input logic [15:0] imm);
      regControl = rc;
      regACont   = ra;
      regBCont   = rb;
      AluOp      = op;
      immediate  = imm;
   endtask

   initial begin
      Reset = 1'b0;
      drive(16'h0001, 4'd0, 4'd0, MOVI, 16'h0001);

      // Table: writes, reads (MOV with rc=0 exposes busB on aluResult), flag ops.
      vt.push_back(v(16'h0003, 0, 0, MOVI, 16'h0001, 16'h0000, 16'h0001, 5'b00000, 16'h0000, 1));
      vt.push_back(v(16'h0001, 0, 0, MOVI, 16'h0001, 16'h0000, 16'h0001, 5'b00000, 16'h0001, 1));
      vt.push_back(v(16'h0002, 1, 0, MOVI, 16'h0001, 16'h0000, 16'h0001, 5'b00000, 16'h0001, 1));
      vt.push_back(v(16'h0000, 0, 1, MOV,  16'h0000, 16'h0001, 16'h0001, 5'b00000, 16'h0001, 1));
      vt.push_back(v(16'h0004, 1, 1, LSH,  16'h0000, 16'h0001, 16'h0002, 5'b00000, 16'h0002, 1));
      vt.push_back(v(16'h0008, 2, 2, LSH,  16'h0000, 16'h0002, 16'h0008, 5'b00000, 16'h0008, 1));
      vt.push_back(v(16'h0010, 3, 0, MOVI, 16'h0007, 16'h0008, 16'h0007, 5'b00000, 16'h0007, 1));
      vt.push_back(v(16'h0040, 4, 3, SUB,  16'h0000, 16'h0007, 16'hFFFF, 5'b11001, 16'hFFFF, 1));
      vt.push_back(v(16'h0008, 3, 3, CMP,  16'h0000, 16'h0008, 16'h0000, 5'b00010, 16'hFFFF, 1));
      vt.push_back(v(16'h0000, 3, 3, MOV,  16'h0000, 16'h0008, 16'h0008, 5'b00010, 16'hFFFF, 1));
      vt.push_back(v(16'h0080, 6, 0, MOVI, 16'h7FFF, 16'hFFFF, 16'h7FFF, 5'b00010, 16'h7FFF, 1));
      vt.push_back(v(16'h0100, 7, 1, ADD,  16'h0000, 16'h7FFF, 16'h8000, 5'b00101, 16'h8000, 1));
      vt.push_back(v(16'h0200, 8, 0, MOVI, 16'hFFFF, 16'h8000, 16'hFFFF, 5'b00101, 16'hFFFF, 1));
      vt.push_back(v(16'h0400, 9, 1, ADD,  16'h0000, 16'hFFFF, 16'h0000, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000,10,10, MOV,  16'h0000, 16'h0000, 16'h0000, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 7, 6, AND_, 16'h0000, 16'h7FFF, 16'h7FFF, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 8, 4, OR_,  16'h0000, 16'h8000, 16'h8007, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 6, 7, XOR_, 16'h0000, 16'hFFFF, 16'h8000, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 7, 0, NOT_, 16'h0000, 16'h7FFF, 16'h8000, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 8, 3, RSH,  16'h0000, 16'h8000, 16'h0080, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 8, 3, ASH,  16'h0000, 16'h8000, 16'hFF80, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 8, 6, ASH,  16'h0000, 16'h8000, 16'hFFFF, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 1, 6, LSH,  16'h0000, 16'h0001, 16'h8000, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 8, 6, RSH,  16'h0000, 16'h8000, 16'h0001, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0000, 7,10, LSH,  16'h0000, 16'h7FFF, 16'h7FFF, 5'b10010, 16'h0000, 1));
      vt.push_back(v(16'h0800, 4, 0, ADDI, 16'h0010, 16'h0007, 16'h0017, 5'b00000, 16'h0017, 1));
      vt.push_back(v(16'h1000,11, 0, LUI,  16'h12AB, 16'h0017, 16'hAB00, 5'b00000, 16'hAB00, 1));
      vt.push_back(v(16'h0020,12, 0, MOVI, 16'h1234, 16'hAB00, 16'h1234, 5'b00000, 16'h1234, 1));
      vt.push_back(v(16'h0020, 5, 0, MOVI, 16'hABCD, 16'h1234, 16'hABCD, 5'b00000, 16'hABCD, 1));
      vt.push_back(v(16'h0000, 5, 5, MOV,  16'h0000, 16'hABCD, 16'hABCD, 5'b00000, 16'hABCD, 1));
      vt.push_back(v(16'h0000, 4, 3, CMP,  16'h0000, 16'h0007, 16'hFFFF, 5'b11001, 16'hABCD, 1));
      vt.push_back(v(16'h0020, 5, 0, 8'h20,16'h0000, 16'hABCD, 16'h0000, 5'b11001, 16'hABCD, 1));
      vt.push_back(v(16'h0001, 0, 0, 8'h0E,16'h0000, 16'h0001, 16'h0000, 5'b11001, 16'hABCD, 1));
      vt.push_back(v(16'h0003, 1, 1, SUB,  16'h0000, 16'h0001, 16'h0000, 5'b00010, 16'hABCD, 1));
      vt.push_back(v(16'h0000, 0, 5, MOV,  16'h0000, 16'h0001, 16'hABCD, 5'b00010, 16'hABCD, 1));

      // Reset held across edges with a write pending: everything stays 0.
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst busA", busA, 16'h0000);
      chk("rst aluResult", aluResult, 16'h0000);
      chk("rst lastResult", lastResult, 16'h0000);
      chk("rst flags", {11'd0, flags}, 16'h0000);
      chk("rst errSticky", {15'd0, errSticky}, 16'h0000);
      // First edge after release is held: the pending MOVI must not land.
      Reset = 1'b1;
      #2;
      chk("release aluResult", aluResult, 16'h0000);
      @(posedge clock);
      #1;
      chk("release R0", busA, 16'h0000);
      chk("release lastResult", lastResult, 16'h0000);

      foreach (vt[k]) begin
         @(negedge clock);
         drive(vt[k].rc, vt[k].ra, vt[k].rb, vt[k].op, vt[k].imm);
         #2;
         chk($sformatf("v%0d busA", k), busA, vt[k].ea);
         chk($sformatf("v%0d aluResult", k), aluResult, vt[k].ealu);
         @(posedge clock);
         #1;
         chk($sformatf("v%0d flags", k), {11'd0, flags}, {11'd0, vt[k].ef});
         chk($sformatf("v%0d lastResult", k), lastResult, vt[k].elast);
         chk($sformatf("v%0d errSticky", k), {15'd0, errSticky}, {15'd0, vt[k].eerr});
      end

      // Same-register read/write seen as old value then new after the edge.
      @(negedge clock);
      drive(16'h0020, 4'd5, 4'd5, MOVI, 16'h0F0F);
      #2;
      chk("rw busA old", busA, 16'hABCD);
      @(posedge clock);
      #1;
      chk("rw busA new", busA, 16'h0F0F);

      // Reset asserted mid-stream with a MOVI 0x5555 into R0 pending.
      @(negedge clock);
      drive(16'h0001, 4'd0, 4'd0, MOVI, 16'h5555);
      #2;
      chk("mid pre R0", busA, 16'h0001);
      Reset = 1'b0;
      #1;
      chk("mid busA", busA, 16'h0000);
      chk("mid aluResult", aluResult, 16'h0000);
      chk("mid lastResult", lastResult, 16'h0000);
      chk("mid flags", {11'd0, flags}, 16'h0000);
      chk("mid errSticky", {15'd0, errSticky}, 16'h0000);
      @(posedge clock);
      #1;
      chk("mid edge R0", busA, 16'h0000);
      @(negedge clock);
      Reset = 1'b1;
      #2;
      chk("mid release aluResult", aluResult, 16'h0000);
      @(posedge clock);
      #1;
      chk("mid release R0", busA, 16'h0000);
      chk("mid release lastResult", lastResult, 16'h0000);
      @(negedge clock);
      drive(16'h0000, 4'd0, 4'd0, MOV, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
